store_checker: RTL and testbench
================================

STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address and data width.
REQ-002 SHALL have parameter DEPTH, default 4, number of expected-store table entries (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, RUN-cycle budget before timeout.
REQ-004 SHALL have parameters IGNORE_BASE, default 80, and IGNORE_MASK, default all-ones, defining tolerated stores.
REQ-005 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port memwrite  in  1  store strobe from the processor.
REQ-008 SHALL have ports dataadr, writedata  in  WIDTH  store address and data.
REQ-009 SHALL have ports exp_we  in  1; exp_idx  in  clog2(DEPTH); exp_adr, exp_data  in  WIDTH  table load.
REQ-010 SHALL have ports exp_count  in  clog2(DEPTH+1)  entries to check; start  in  1  arm pulse.
REQ-011 SHALL have ports done, pass  out  1; fail_code  out  2 (00 none, 01 mismatch, 10 timeout).
REQ-012 SHALL have ports match_count  out  clog2(DEPTH+1); fail_adr, fail_data  out  WIDTH.

Function
REQ-013 SHALL implement states IDLE, RUN, PASS, FAIL; all outputs registered.
REQ-014 IDLE: exp_we writes entry exp_idx; exp_we in any other state SHALL be ignored.
REQ-015 start in IDLE, PASS or FAIL SHALL latch exp_count, zero match pointer and cycle counter, clear done/pass/fail_code/fail_adr/fail_data, enter RUN; start in RUN ignored.
REQ-016 start with exp_count 0 SHALL enter PASS next cycle; exp_count > DEPTH SHALL saturate to DEPTH.
REQ-017 memwrite sampled on the start cycle SHALL NOT be checked.
REQ-018 RUN, memwrite=1, dataadr and writedata equal to entry[ptr]: ptr and match_count increment; if ptr reaches exp_count, enter PASS.
REQ-019 RUN, memwrite=1, no match, (dataadr & IGNORE_MASK)==(IGNORE_BASE & IGNORE_MASK): no effect.
REQ-020 Expected-entry match SHALL take priority over ignore match.
REQ-021 RUN, memwrite=1, neither match: enter FAIL, fail_code=01, capture dataadr/writedata into fail_adr/fail_data.
REQ-022 PASS: done=1, pass=1; FAIL: done=1, pass=0; both hold until start or reset; memwrite ignored.
REQ-023 Outputs SHALL reflect a decision on the rising edge after the deciding sample (latency 1).
REQ-024 match_count SHALL never exceed exp_count; ptr SHALL never index past DEPTH-1.

Reset
REQ-025 reset SHALL force IDLE, clear table, ptr, cycle counter, done, pass, fail_code, match_count, fail_adr, fail_data to 0, overriding all inputs including mid-RUN.

Configuration
REQ-026 With STORE_CHECKER_TIMEOUT_EN defined: cycle counter increments each RUN cycle; when it reaches TIMEOUT_CYCLES-1 without decision, enter FAIL, fail_code=10, fail_adr/fail_data=0.
REQ-027 Final match and timeout on the same cycle SHALL yield PASS; mismatch and timeout on the same cycle SHALL yield code 01.
REQ-028 Without STORE_CHECKER_TIMEOUT_EN: no cycle counter synthesized, RUN waits indefinitely, code 10 never produced.

Structure
REQ-029 Package store_checker_pkg SHALL hold the state enum and fail_code constants (FC_NONE, FC_MISMATCH, FC_TIMEOUT).
REQ-030 Expected-store table with load port and indexed read SHALL be sub-module store_checker_table.

Verification
REQ-031 Table {(84,7)}, count 1, start; stores (80,7),(84,7) -> done=1, pass=1, match_count=1 next cycle.
REQ-032 Same setup; store (88,7) -> done=1, pass=0, fail_code=01, fail_adr=88, fail_data=7.
REQ-033 Same setup; store (84,6) -> fail_code=01, fail_data=6; then start, store (84,7) -> pass=1.
REQ-034 Table {(84,7),(88,3)}, count 2; stores (88,3) first -> fail_code=01, match_count=0.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES=16, start, no stores -> fail_code=10 on the 16th RUN cycle; no macro -> done stays 0 for 100 cycles.
REQ-036 reset asserted mid-RUN after one match -> next cycle all outputs 0, state IDLE, table entry reads 0.

Source files
------------

// File: rtl/store_checker_pkg.sv
// -----------------------------------------------------------------------------
// store_checker_pkg
// Shared definitions for the store checker: FSM state encoding, failure-code
// constants and a small helper that clamps the requested entry count to the
// table depth.
// -----------------------------------------------------------------------------
package store_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISMATCH = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  // A request for more entries than the table holds checks the whole table.
  function automatic int sat_count(input int count, input int depth);
    if (count > depth) begin
      return depth;
    end else begin
      return count;
    end
  endfunction

endpackage

// File: rtl/store_checker_table.sv
// -----------------------------------------------------------------------------
// store_checker_table
// Expected-store table: DEPTH entries of {address, data}, one write port and
// one combinational indexed read port. Reset clears every entry to zero.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   we, wr_idx          write strobe and entry index
//   wr_adr, wr_data     entry contents to write
//   rd_idx              entry index to read
//   rd_adr, rd_data     contents of entry rd_idx (zero if out of range)
// -----------------------------------------------------------------------------
module store_checker_table #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_adr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_adr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] adr_q  [DEPTH];
  logic [WIDTH-1:0] adr_d  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Next-state of each entry: overwrite the addressed entry, hold the rest.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (wr_idx == IDX_W'(i))) begin
        adr_d[i]  = wr_adr;
        data_d[i] = wr_data;
      end else begin
        adr_d[i]  = adr_q[i];
        data_d[i] = data_q[i];
      end
    end
  end

  // Entry storage with synchronous clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
      end else begin
        adr_q[i]  <= adr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Indexed read; an index beyond the table (non-power-of-two DEPTH) reads zero.
  always_comb begin
    if (int'(rd_idx) < DEPTH) begin
      rd_adr  = adr_q[rd_idx];
      rd_data = data_q[rd_idx];
    end else begin
      rd_adr  = '0;
      rd_data = '0;
    end
  end

endmodule

// File: rtl/store_checker.sv
// -----------------------------------------------------------------------------
// store_checker
// Watches a processor's store stream and checks it against an ordered table of
// expected {address, data} stores. Stores to the tolerated address region
// (IGNORE_BASE under IGNORE_MASK) are skipped unless they are the expected
// store. The verdict (PASS / FAIL with code and offending store) is held until
// the next start or reset. All outputs are registered.
//
// Optional feature: define STORE_CHECKER_TIMEOUT_EN to add a RUN-cycle budget
// of TIMEOUT_CYCLES, after which the check fails with code FC_TIMEOUT.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   memwrite, dataadr,
//   writedata                  store strobe, address and data from the CPU
//   exp_we, exp_idx,
//   exp_adr, exp_data          table load (honoured only in IDLE)
//   exp_count, start           number of entries to check, arm pulse
//   done, pass, fail_code      verdict (fail_code 00 none, 01 mismatch, 10 timeout)
//   match_count                number of expected stores matched so far
//   fail_adr, fail_data        offending store on a mismatch
// -----------------------------------------------------------------------------
module store_checker
  import store_checker_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               DEPTH          = 4,
  parameter int               TIMEOUT_CYCLES = 1000,
  parameter logic [WIDTH-1:0] IGNORE_BASE    = WIDTH'(80),
  parameter logic [WIDTH-1:0] IGNORE_MASK    = '1,
  localparam int              IDX_W          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int              CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_idx,
  input  logic [WIDTH-1:0] exp_adr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [CNT_W-1:0] exp_count,
  input  logic             start,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] match_count,
  output logic [WIDTH-1:0] fail_adr,
  output logic [WIDTH-1:0] fail_data
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [WIDTH-1:0] fail_adr_q, fail_adr_d;
  logic [WIDTH-1:0] fail_data_q, fail_data_d;

  logic             tbl_we_s;
  logic [WIDTH-1:0] tbl_adr_s;
  logic [WIDTH-1:0] tbl_data_s;
  logic             arm_s;
  logic             hit_exp_s;
  logic             hit_ign_s;
  logic             timeout_s;
  logic [CNT_W-1:0] sat_count_s;

  // Table loads are only accepted while idle so a running check sees a stable table.
  assign tbl_we_s    = exp_we && (state_q == ST_IDLE);
  assign arm_s       = start && (state_q != ST_RUN);
  assign sat_count_s = CNT_W'(sat_count(int'(exp_count), DEPTH));
  assign hit_exp_s   = (tbl_adr_s == dataadr) && (tbl_data_s == writedata);
  assign hit_ign_s   = ((dataadr & IGNORE_MASK) == (IGNORE_BASE & IGNORE_MASK));

  store_checker_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .we      (tbl_we_s),
    .wr_idx  (exp_idx),
    .wr_adr  (exp_adr),
    .wr_data (exp_data),
    .rd_idx  (ptr_q),
    .rd_adr  (tbl_adr_s),
    .rd_data (tbl_data_s)
  );

`ifdef STORE_CHECKER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] cyc_q, cyc_d;

  // RUN-cycle counter: zeroed on arm, advances every RUN cycle.
  always_comb begin
    if (arm_s) begin
      cyc_d = '0;
    end else if (state_q == ST_RUN) begin
      cyc_d = cyc_q + TW'(1);
    end else begin
      cyc_d = cyc_q;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign timeout_s = (state_q == ST_RUN) && (cyc_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Checker FSM next-state and verdict logic.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    count_d       = count_q;
    match_count_d = match_count_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_code_d   = fail_code_q;
    fail_adr_d    = fail_adr_q;
    fail_data_d   = fail_data_q;

    if (arm_s) begin
      // The store sampled on this cycle is deliberately not checked.
      count_d       = sat_count_s;
      ptr_d         = '0;
      match_count_d = '0;
      fail_code_d   = FC_NONE;
      fail_adr_d    = '0;
      fail_data_d   = '0;
      if (sat_count_s == CNT_W'(0)) begin
        state_d = ST_PASS;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (memwrite && hit_exp_s) begin
            // An expected match wins over the ignore window and over a timeout
            // only when it completes the sequence.
            match_count_d = match_count_q + CNT_W'(1);
            if ((match_count_q + CNT_W'(1)) == count_q) begin
              state_d = ST_PASS;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end else if (timeout_s) begin
              state_d     = ST_FAIL;
              done_d      = 1'b1;
              fail_code_d = FC_TIMEOUT;
            end else begin
              ptr_d = ptr_q + IDX_W'(1);
            end
          end else if (memwrite && !hit_ign_s) begin
            state_d     = ST_FAIL;
            done_d      = 1'b1;
            fail_code_d = FC_MISMATCH;
            fail_adr_d  = dataadr;
            fail_data_d = writedata;
          end else if (timeout_s) begin
            state_d     = ST_FAIL;
            done_d      = 1'b1;
            fail_code_d = FC_TIMEOUT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      count_q       <= '0;
      match_count_q <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= FC_NONE;
      fail_adr_q    <= '0;
      fail_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      match_count_q <= match_count_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_code_q   <= fail_code_d;
      fail_adr_q    <= fail_adr_d;
      fail_data_q   <= fail_data_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_code_q;
  assign match_count = match_count_q;
  assign fail_adr    = fail_adr_q;
  assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_store_checker.sv
// -----------------------------------------------------------------------------
// tb_store_checker
// Scoreboard bench for store_checker (WIDTH 32, DEPTH 4, TIMEOUT_CYCLES 16).
// Each cycle the expected output vector {done, pass, fail_code, match_count,
// fail_adr, fail_data} is pushed when stimulus is driven and popped and
// compared one clock later, #1 after the rising edge.
// -----------------------------------------------------------------------------
module tb_store_checker;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic [1:0]  code;
    logic [2:0]  mc;
    logic [31:0] fadr;
    logic [31:0] fdata;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic        exp_we = 1'b0;
  logic [1:0]  exp_idx = 2'd0;
  logic [31:0] exp_adr = 32'd0;
  logic [31:0] exp_data = 32'd0;
  logic [2:0]  exp_count = 3'd0;
  logic        start = 1'b0;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [2:0]  match_count;
  logic [31:0] fail_adr;
  logic [31:0] fail_data;

  res_t obs;
  res_t e;
  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam res_t ZERO = '0;

  always #5 clk = ~clk;

  assign obs = {done, pass, fail_code, match_count, fail_adr, fail_data};

  store_checker #(
    .WIDTH          (32),
    .DEPTH          (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .exp_we      (exp_we),
    .exp_idx     (exp_idx),
    .exp_adr     (exp_adr),
    .exp_data    (exp_data),
    .exp_count   (exp_count),
    .start       (start),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .match_count (match_count),
    .fail_adr    (fail_adr),
    .fail_data   (fail_data)
  );

  function automatic res_t mk(input logic d, input logic p, input logic [1:0] c,
                              input logic [2:0] m, input logic [31:0] a,
                              input logic [31:0] w);
    res_t r;
    r = {d, p, c, m, a, w};
    return r;
  endfunction

  // Drive one cycle of store stimulus; start/exp_we are single-cycle pulses.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    start    = 1'b0;
    exp_we   = 1'b0;
  endtask

  task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    exp_we  = 1'b1;
    exp_idx = idx;
    exp_adr = a;
    exp_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    exp_q.push_back(ZERO); step(1'b1, 32'd5, 32'd5);
    reset = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset: got %h expected %h", obs, e); end
  endtask

  task automatic test_basic_pass();
    load(2'd0, 32'd84, 32'd7);
    exp_q.push_back(ZERO); step(1'b0, 32'd0, 32'd0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL load_idle: got %h expected %h", obs, e); end
    start = 1'b1; exp_count = 3'd1;
    exp_q.push_back(ZERO); step(1'b0, 32'd0, 32'd0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL arm: got %h expected %h", obs, e); end
    exp_q.push_back(ZERO); step(1'b1, 32'd80, 32'd7);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ignore_store: got %h expected %h", obs, e); end
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 3'd1, 32'd0, 32'd0)); step(1'b1, 32'd84, 32'd7);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL final_match: got %h expected %h", obs, e); end
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 3'd1, 32'd0, 32'd0)); step(1'b1, 32'd88, 32'd7);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL pass_hold: got %h expected %h", obs, e); end
  endtask

  task automatic test_mismatch();
    start = 1'b1; exp_count = 3'd1;
    exp_q.push_back(ZERO); step(1'b0, 32'd0, 32'd0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rearm_clear: got %h expected %h", obs, e); end
    exp_q.push_back(mk(1'b1, 1'b0, 2'b01, 3'd0, 32'd88, 32'd7)); step(1'b1, 32'd88, 32'd7);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL adr_mismatch: got %h expected %h", obs, e); end
    exp_q.push_back(mk(1'b1, 1'b0, 2'b01, 3'd0, 32'd88, 32'd7)); step(1'b1, 32'd84, 32'd7);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL fail_hold: got %h expected %h", obs, e); end
  endtask

  task automatic test_data_mismatch();
    start = 1'b1; exp_count = 3'd1;
    exp_q.push_back(ZERO); step(1'b0, 32'd0, 32'd0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rearm_from_fail: got %h expected %h", obs, e); end
    exp_q.push_back(mk(1'b1, 1'b0, 2'b01, 3'd0, 32'd84, 32'd6)); step(1'b1, 32'd84, 32'd6);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL data_mismatch: got %h expected %h", obs, e); end
    start = 1'b1; exp_count = 3'd1;
    exp_q.push_back(ZERO); step(1'b0, 32'd0, 32'd0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rearm_clears_fail: got %h expected %h", obs, e); end
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 3'd1, 32'd0, 32'd0)); step(1'b1, 32'd84, 32'd7);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL retry_pass: got %h expected %h", obs, e); end
  endtask

  task automatic test_order();
    test_reset();
    load(2'd0, 32'd84, 32'd7); step(1'b0, 32'd0, 32'd0);
    load(2'd1, 32'd88, 32'd3); step(1'b0, 32'd0, 32'd0);
    start = 1'b1; exp_count = 3'd2; step(1'b0, 32'd0, 32'd0);
    exp_q.push_back(mk(1'b1, 1'b0, 2'b01, 3'd0, 32'd88, 32'd3)); step(1'b1, 32'd88, 32'd3);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL out_of_order: got %h expected %h", obs, e); end
    start = 1'b1; exp_count = 3'd2; step(1'b0, 32'd0, 32'd0);
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 3'd1, 32'd0, 32'd0)); step(1'b1, 32'd84, 32'd7);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL partial_match: got %h expected %h", obs, e); end
    start = 1'b1; exp_count = 3'd1;
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 3'd1, 32'd0, 32'd0)); step(1'b0, 32'd0, 32'd0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL start_in_run: got %h expected %h", obs, e); end
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 3'd1, 32'd0, 32'd0)); step(1'b1, 32'd80, 32'd99);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ignore_mid_run: got %h expected %h", obs, e); end
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 3'd2, 32'd0, 32'd0)); step(1'b1, 32'd88, 32'd3);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ordered_pass: got %h expected %h", obs, e); end
  endtask

  task automatic test_we_ignored();
    load(2'd1, 32'd88, 32'd9);
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 3'd2, 32'd0, 32'd0)); step(1'b0, 32'd0, 32'd0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL we_in_pass: got %h expected %h", obs, e); end
    start = 1'b1; exp_count = 3'd2;
    exp_q.push_back(ZERO); step(1'b1, 32'd12, 32'd12);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL store_on_start: got %h expected %h", obs, e); end
    step(1'b1, 32'd84, 32'd7);
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 3'd2, 32'd0, 32'd0)); step(1'b1, 32'd88, 32'd3);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL table_unchanged: got %h expected %h", obs, e); end
  endtask

  task automatic test_count_zero();
    start = 1'b1; exp_count = 3'd0;
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 3'd0, 32'd0, 32'd0)); step(1'b1, 32'd7, 32'd7);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL count_zero: got %h expected %h", obs, e); end
  endtask

  task automatic test_saturate();
    test_reset();
    for (int i = 0; i < 4; i++) begin
      load(2'(i), 32'(100 + 4 * i), 32'(i + 1)); step(1'b0, 32'd0, 32'd0);
    end
    start = 1'b1; exp_count = 3'd7; step(1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 3'(i + 1), 32'd0, 32'd0));
      else       exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 3'd4, 32'd0, 32'd0));
      step(1'b1, 32'(100 + 4 * i), 32'(i + 1));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL saturate_%0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_timeout();
`ifdef STORE_CHECKER_TIMEOUT_EN
    start = 1'b1; exp_count = 3'd1; step(1'b0, 32'd0, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      if (i < 16) exp_q.push_back(ZERO);
      else        exp_q.push_back(mk(1'b1, 1'b0, 2'b10, 3'd0, 32'd0, 32'd0));
      step(1'b0, 32'd0, 32'd0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout_cyc%0d: got %h expected %h", i, obs, e); end
    end
    start = 1'b1; exp_count = 3'd1; step(1'b0, 32'd0, 32'd0);
    for (int i = 1; i < 16; i++) step(1'b0, 32'd0, 32'd0);
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 3'd1, 32'd0, 32'd0)); step(1'b1, 32'd100, 32'd1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL match_at_timeout: got %h expected %h", obs, e); end
    start = 1'b1; exp_count = 3'd1; step(1'b0, 32'd0, 32'd0);
    for (int i = 1; i < 16; i++) step(1'b0, 32'd0, 32'd0);
    exp_q.push_back(mk(1'b1, 1'b0, 2'b01, 3'd0, 32'd5, 32'd5)); step(1'b1, 32'd5, 32'd5);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL mismatch_at_timeout: got %h expected %h", obs, e); end
`else
    start = 1'b1; exp_count = 3'd1; step(1'b0, 32'd0, 32'd0);
    for (int i = 1; i <= 100; i++) begin
      exp_q.push_back(ZERO); step(1'b0, 32'd0, 32'd0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL no_timeout_cyc%0d: got %h expected %h", i, obs, e); end
    end
`endif
  endtask

  task automatic test_reset_midrun();
    test_reset();
    load(2'd0, 32'd84, 32'd7); step(1'b0, 32'd0, 32'd0);
    load(2'd1, 32'd88, 32'd3); step(1'b0, 32'd0, 32'd0);
    start = 1'b1; exp_count = 3'd2; step(1'b0, 32'd0, 32'd0);
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 3'd1, 32'd0, 32'd0)); step(1'b1, 32'd84, 32'd7);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL pre_reset_match: got %h expected %h", obs, e); end
    reset = 1'b1;
    exp_q.push_back(ZERO); step(1'b1, 32'd1, 32'd1);
    reset = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL midrun_reset: got %h expected %h", obs, e); end
    // A cleared table holds (0,0) in entry 0, so that store must complete a 1-entry check.
    start = 1'b1; exp_count = 3'd1;
    exp_q.push_back(ZERO); step(1'b0, 32'd0, 32'd0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL idle_after_reset: got %h expected %h", obs, e); end
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 3'd1, 32'd0, 32'd0)); step(1'b1, 32'd0, 32'd0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL table_cleared: got %h expected %h", obs, e); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic_pass();
    test_mismatch();
    test_data_mismatch();
    test_order();
    test_we_ignored();
    test_count_zero();
    test_saturate();
    test_timeout();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
